imem_loader: RTL



---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_ram.sv | 23 ++
 rtl/imem_loader.sv | 102 ++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared states, constants and stream field sizes for the instruction loader
package imem_pkg;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [31:0] INST_NOP   = 32'h0000_0013;
  localparam int          LEN_BYTES  = 2;
  localparam int          CSUM_BYTES = 1;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - DEPTH x 32 instruction RAM, synchronous write, asynchronous read
module imem_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // No reset: the loader gates reads by the loaded word count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - receives, checks and stores a program, then releases the core and serves inst
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic        core_nrst,
  output logic        busy,
  output logic        err
);

  localparam int CW = 17;

  state_t            state;
  logic [15:0]       n_words;
  logic [ADDR_W:0]   widx;
  logic [1:0]        bcnt;
  logic [23:0]       asm_q;
  logic [7:0]        csum;

  logic              accept;
  logic              ram_we;
  logic              last_word;
  logic              len_bad;
  logic [31:0]       ram_rdata;
  logic              read_hit;

  assign accept    = rx_valid && rx_ready;
  assign ram_we    = accept && (state == S_DATA) && (bcnt == 2'd3);
  assign last_word = (CW'(widx) + CW'(1)) == CW'(n_words);
  assign len_bad   = ({rx_data, n_words[7:0]} == 16'd0) ||
                     (CW'({rx_data, n_words[7:0]}) > CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= S_LEN0;
      n_words   <= '0;
      widx      <= '0;
      bcnt      <= '0;
      asm_q     <= '0;
      csum      <= '0;
      core_nrst <= 1'b0;
    end else if (accept) begin
      unique case (state)
        S_LEN0: begin
          n_words[7:0] <= rx_data;
          state        <= S_LEN1;
        end
        S_LEN1: begin
          n_words[15:8] <= rx_data;
          state         <= len_bad ? S_ERR : S_DATA;
        end
        S_DATA: begin
          // Bytes arrive LSB first, so shift in from the top.
          asm_q <= {rx_data, asm_q[23:8]};
          csum  <= csum ^ rx_data;
          bcnt  <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            widx <= widx + 1'b1;
            if (last_word) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (rx_data == csum) begin
            state     <= S_RUN;
            core_nrst <= 1'b1;
          end else begin
            state <= S_ERR;
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign rx_ready = (state == S_LEN0) || (state == S_LEN1) ||
                    (state == S_DATA) || (state == S_CSUM);
  assign busy     = (state == S_LEN1) || (state == S_DATA) || (state == S_CSUM);
  assign err      = (state == S_ERR);

  imem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (widx[ADDR_W-1:0]),
    .wdata ({rx_data, asm_q}),
    .raddr (pc[ADDR_W+1:2]),
    .rdata (ram_rdata)
  );

  assign read_hit = (state == S_RUN) && (pc[1:0] == 2'b00) &&
                    (pc[31:2] < {14'd0, n_words});
  assign inst     = read_hit ? ram_rdata : INST_NOP;

endmodule
